// File: rtl/orion_arb_pkg.sv
// Shared types for the orion transmit arbiter: FSM state encoding and the
// ack watchdog counter width.
package orion_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2
  } orion_arb_state_e;

  localparam int ORION_ARB_TO_W = 16;

endpackage

// File: rtl/orion_sync_bit.sv
// Single-bit flop-chain synchronizer; STAGES flops, synchronous reset to 0.
module orion_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/orion_tx_arbiter.sv
// Round-robin arbiter driving one 2-phase bundled-data channel from NUM_REQ
// clocked requesters. Optional ack watchdog: ORION_TX_ARB_TIMEOUT_EN.
module orion_tx_arbiter
  import orion_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic                       out_req,
  input  logic                       out_ack,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output orion_arb_state_e           dbg_state_o
);

  localparam int IDW = $clog2(NUM_REQ);

  // Handshake: a word transfers on a clock edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is only ever asserted in IDLE.
  orion_arb_state_e state_q, state_d;
  logic             out_req_q, out_req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   winner;
  logic [WIDTH-1:0] winner_data;
  logic             ack_s;

  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     last);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  orion_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i(clock),
    .rst_i(reset),
    .d_i  (out_ack),
    .q_o  (ack_s)
  );

  assign winner = rr_pick(req_valid, last_q);

  always_comb begin
    winner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        winner_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    out_req_d = out_req_q;
    data_d    = data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[winner] = 1'b1;
          data_d            = winner_data;
          grant_d           = winner;
          last_d            = winner;
          state_d           = SETUP;
        end
      end
      SETUP: begin
        out_req_d = ~out_req_q;
        state_d   = WAIT;
      end
      WAIT: begin
        // Early acks seen in IDLE/SETUP are resolved here by phase compare.
        if (ack_s == out_req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      out_req_q <= 1'b0;
      data_q    <= '0;
      grant_q   <= '0;
      last_q    <= IDW'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      out_req_q <= out_req_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

`ifdef ORION_TX_ARB_TIMEOUT_EN
  localparam logic [ORION_ARB_TO_W-1:0] TO_LIMIT = ORION_ARB_TO_W'(TIMEOUT_CYCLES);

  logic [ORION_ARB_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic                      to_err_q, to_err_d;

  // Counter saturates at the limit; the FSM keeps waiting for a late ack.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    if (state_q == SETUP) begin
      to_cnt_d = '0;
    end else if (state_q == WAIT && to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_d == TO_LIMIT) begin
        to_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_err        = 1'b0;
`endif

  assign out_req     = out_req_q;
  assign out_data    = data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_orion_tx_arbiter.sv
// Bench for orion_tx_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a round-robin reference model.
module tb_orion_tx_arbiter;
  import orion_arb_pkg::*;

  localparam int SYNC = 2;
  localparam int TO_CYCLES = 10;
`ifdef ORION_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [31:0]      req_data;
  logic             out_req;
  logic             out_ack;
  logic [7:0]       out_data;
  logic [1:0]       grant_id;
  logic             busy;
  logic             timeout_err;
  orion_arb_state_e dbg_state;

  orion_tx_arbiter #(
    .NUM_REQ(4), .WIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .out_req(out_req), .out_ack(out_ack),
    .out_data(out_data), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "bench time limit");
  end

  // scoreboard state
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic       model_phase = 1'b0;
  int         model_last = 3;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          exp_id;
    int          ack_dly;
    bit          hold;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [3:0] mask, input int last);
    for (int off = 1; off <= 4; off++) begin
      if (mask[2'((last + off) % 4)]) return (last + off) % 4;
    end
    return -1;
  endfunction

  // driver: one complete transfer, entered and left at a negedge in IDLE
  task automatic xfer(input logic [3:0] mask, input logic [31:0] data,
                      input int exp_id, input int ack_dly, input bit hold);
    logic [7:0] exp_d;
    int n;
    req_valid = mask;
    req_data  = data;
    #1;
    check("ready_onehot", 32'(req_ready), 32'(1 << exp_id));
    exp_d = data[exp_id*8 +: 8];
    exp_q.push_back(exp_d);
    @(posedge clock);
    #1;
    if (!hold) req_valid = '0;
    @(negedge clock);
    check("setup_data", 32'(out_data), 32'(exp_d));
    check("grant_id", 32'(grant_id), 32'(exp_id));
    check("setup_req_held", 32'(out_req), 32'(model_phase));
    check("setup_ready_low", 32'(req_ready), 32'd0);
    check("setup_busy", 32'(busy), 32'd1);
    @(negedge clock);
    model_phase = ~model_phase;
    check("req_toggle", 32'(out_req), 32'(model_phase));
    check("wait_state", 32'(dbg_state), 32'(WAIT));
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clock);
      check("wait_data_stable", 32'(out_data), 32'(exp_d));
      check("wait_ready_low", 32'(req_ready), 32'd0);
    end
    out_ack = model_phase;
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("ack_latency", 32'(n), 32'(SYNC + 1));
    check("done_data", 32'(out_data), 32'(exp_q.pop_front()));
    model_last = exp_id;
  endtask

  initial begin
    logic [7:0] hold_d;
    int         exp_id;
    int         n;
    logic [3:0] mask;
    logic [31:0] data;

    vecs[0]  = '{4'b0100, 32'h00A5_0000, 2, 0, 1'b0};
    vecs[1]  = '{4'b1111, 32'h4433_2211, 3, 3, 1'b1};
    vecs[2]  = '{4'b1111, 32'h5A6B_7C8D, 0, 3, 1'b1};
    vecs[3]  = '{4'b1111, 32'h0102_0304, 1, 3, 1'b1};
    vecs[4]  = '{4'b1111, 32'hF0E1_D2C3, 2, 3, 1'b1};
    vecs[5]  = '{4'b1111, 32'h9988_7766, 3, 3, 1'b1};
    vecs[6]  = '{4'b1111, 32'h1357_9BDF, 0, 3, 1'b0};
    vecs[7]  = '{4'b0110, 32'hAABB_CCDD, 1, 1, 1'b0};
    vecs[8]  = '{4'b0110, 32'h1122_3344, 2, 2, 1'b0};
    vecs[9]  = '{4'b0011, 32'hDEAD_BEEF, 0, 0, 1'b0};
    vecs[10] = '{4'b1000, 32'hCAFE_F00D, 3, 4, 1'b0};
    vecs[11] = '{4'b1001, 32'h0BAD_C0DE, 0, 1, 1'b0};
    vecs[12] = '{4'b1010, 32'h7654_3210, 1, 0, 1'b0};

    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_out_req", 32'(out_req), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // directed table
    for (int v = 0; v < 13; v++) begin
      xfer(vecs[v].mask, vecs[v].data, vecs[v].exp_id, vecs[v].ack_dly, vecs[v].hold);
    end

    // requester 1 held valid with ack withheld; watchdog observed
    exp_id = model_pick(4'b0010, model_last);
    req_valid = 4'b0010;
    req_data = 32'h0000_3C00;
    hold_d = 8'h3C;
    #1;
    check("wh_ready", 32'(req_ready), 32'(1 << exp_id));
    @(negedge clock);
    check("wh_setup_data", 32'(out_data), 32'(hold_d));
    @(negedge clock);
    model_phase = ~model_phase;
    check("wh_toggle", 32'(out_req), 32'(model_phase));
    for (int k = 0; k < 15; k++) begin
      check("wh_ready_low", 32'(req_ready), 32'd0);
      check("wh_data_stable", 32'(out_data), 32'(hold_d));
      check("wh_timeout", 32'(timeout_err), 32'((TO_EN && k >= TO_CYCLES) ? 1 : 0));
      @(negedge clock);
    end
    req_valid = '0;
    out_ack = model_phase;
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("wh_late_ack", 32'(n), 32'(SYNC + 1));
    check("wh_timeout_sticky", 32'(timeout_err), 32'(TO_EN ? 1 : 0));
    model_last = exp_id;

    // reset while in WAIT abandons the token
    req_valid = 4'b0100;
    req_data = 32'h0077_0000;
    @(posedge clock);
    #1 req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    check("rw_in_wait", 32'(dbg_state), 32'(WAIT));
    reset = 1'b1;
    out_ack = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    model_phase = 1'b0;
    model_last = 3;
    check("rw_out_req", 32'(out_req), 32'd0);
    check("rw_state", 32'(dbg_state), 32'(IDLE));
    check("rw_timeout", 32'(timeout_err), 32'd0);
    xfer(4'b1111, 32'h8877_6655, 0, 1, 1'b0);

    // randomized traffic against the reference model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        repeat (2) begin
          @(negedge clock);
          check("idle_busy", 32'(busy), 32'd0);
          check("idle_ready", 32'(req_ready), 32'd0);
        end
      end
      mask = 4'($urandom_range(1, 15));
      data = $urandom;
      xfer(mask, data, model_pick(mask, model_last),
           $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    req_valid = '0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
